// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the dual-lane memory stage.
package mem_stage_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  typedef enum logic {IDLE, SECOND} state_t;
  typedef struct packed {
    logic          regwrite;
    logic          memtoreg;
    logic [DW-1:0] readdata;
    logic [DW-1:0] aluout;
    logic [RW-1:0] writereg;
  } wb_lane_t;
  localparam wb_lane_t WB_BUBBLE = '0;
endpackage

// File: rtl/memory_stage_dual_wb_lane_reg.sv
// wb_lane_reg: MEM/WB register for one lane; reset beats flush beats stall.
module wb_lane_reg
  import mem_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_stall,
  input  logic     i_flush,
  input  wb_lane_t i_d,
  output wb_lane_t o_q
);
  always_ff @(posedge clk)
    if (reset || i_flush) o_q <= WB_BUBBLE;
    else if (!i_stall) o_q <= i_d;
endmodule

// File: rtl/memory_stage_dual.sv
// memory_stage_dual: arbitrates two pipeline lanes onto one data memory port, splitting
// dual accesses over two cycles (A first) and owning the MEM/WB register.
module memory_stage_dual
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              RegWriteMInA,
  input  logic              MemtoRegMInA,
  input  logic              MemWriteMInA,
  input  logic [DATA_W-1:0] ALUOutMInA,
  input  logic [DATA_W-1:0] WriteDataMInA,
  input  logic [REG_W-1:0]  WriteRegMInA,
  input  logic              RegWriteMInB,
  input  logic              MemtoRegMInB,
  input  logic              MemWriteMInB,
  input  logic [DATA_W-1:0] ALUOutMInB,
  input  logic [DATA_W-1:0] WriteDataMInB,
  input  logic [REG_W-1:0]  WriteRegMInB,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              StallM,
  output logic              RegWriteWInA,
  output logic              MemtoRegWInA,
  output logic [DATA_W-1:0] ReadDataWInA,
  output logic [DATA_W-1:0] ALUOutWInA,
  output logic [REG_W-1:0]  WriteRegWInA,
  output logic              RegWriteWInB,
  output logic              MemtoRegWInB,
  output logic [DATA_W-1:0] ReadDataWInB,
  output logic [DATA_W-1:0] ALUOutWInB,
  output logic [REG_W-1:0]  WriteRegWInB
);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_hold_rdata;
  logic              w_acc_a, w_acc_b, w_split, w_second, w_use_b, w_bubble;
  wb_lane_t          w_d_a, w_d_b, r_wb_a, r_wb_b;
  always_comb begin
    w_acc_a  = MemWriteMInA | MemtoRegMInA;
    w_acc_b  = MemWriteMInB | MemtoRegMInB;
    w_second = r_state == SECOND;
    w_split  = !w_second && w_acc_a && w_acc_b;
    w_use_b  = w_second || (w_acc_b && !w_acc_a);
    w_next   = w_split ? SECOND : IDLE;
    // a split's first cycle retires nothing; stall still wins so the held W values survive
    w_bubble = FlushW || (w_split && !StallW);
    dmem_addr  = w_use_b ? ALUOutMInB[ADDR_W-1:0] : ALUOutMInA[ADDR_W-1:0];
    dmem_wdata = w_use_b ? WriteDataMInB : WriteDataMInA;
    dmem_we    = (w_use_b ? MemWriteMInB : MemWriteMInA) && !StallW && !FlushW && !reset;
    StallM     = w_split && !reset;
    w_d_a = '{RegWriteMInA, MemtoRegMInA,
              w_second ? r_hold_rdata : (w_acc_a ? dmem_rdata : '0),
              ALUOutMInA, WriteRegMInA};
    w_d_b = '{RegWriteMInB, MemtoRegMInB,
              (w_second || w_acc_b) ? dmem_rdata : '0,
              ALUOutMInB, WriteRegMInB};
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state      <= IDLE;
      r_hold_rdata <= '0;
    end else if (FlushW) r_state <= IDLE;
    else if (!StallW) begin
      r_state <= w_next;
      if (w_split) r_hold_rdata <= dmem_rdata;
    end
  wb_lane_reg u_lane_a (.clk, .reset, .i_stall(StallW), .i_flush(w_bubble), .i_d(w_d_a), .o_q(r_wb_a));
  wb_lane_reg u_lane_b (.clk, .reset, .i_stall(StallW), .i_flush(w_bubble), .i_d(w_d_b), .o_q(r_wb_b));
  assign RegWriteWInA = r_wb_a.regwrite;
  assign MemtoRegWInA = r_wb_a.memtoreg;
  assign ReadDataWInA = r_wb_a.readdata;
  assign ALUOutWInA   = r_wb_a.aluout;
  assign WriteRegWInA = r_wb_a.writereg;
  assign RegWriteWInB = r_wb_b.regwrite;
  assign MemtoRegWInB = r_wb_b.memtoreg;
  assign ReadDataWInB = r_wb_b.readdata;
  assign ALUOutWInB   = r_wb_b.aluout;
  assign WriteRegWInB = r_wb_b.writereg;
endmodule
